traffic_sensor_conditioner: RTL and testbench

- Upstream input stage of the traffic-light top level.
- Takes raw asynchronous vehicle-loop detector lines (main and side road) and the raw pedestrian push-button.
- Produces the 3-bit per-road traffic-density levels and a latched pedestrian request that the controller/timer consume.
- Each input is synchronised and debounced. Vehicle arrivals are counted over a fixed sampling window, and each road level is a saturated count refreshed once per window.

---
 rtl/traffic_sensor_conditioner_if.sv | 22 ++
 rtl/traffic_sensor_conditioner.sv | 107 ++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_conditioner_if.sv
// Raw detector/button lines in, per-road density levels and latched ped request out.
// Free-running signals with no handshake; the consumer samples the levels when levelValid pulses.
interface traffic_sensor_conditioner_if;
   logic       mainDetectRaw;
   logic       sideDetectRaw;
   logic       pedButtonRaw;
   logic       pedClear;
   logic [2:0] mainTrafficLevel;
   logic [2:0] sideTrafficLevel;
   logic       levelValid;
   logic       pedRequest;

   modport master (
      output mainDetectRaw, sideDetectRaw, pedButtonRaw, pedClear,
      input  mainTrafficLevel, sideTrafficLevel, levelValid, pedRequest
   );

   modport slave (
      input  mainDetectRaw, sideDetectRaw, pedButtonRaw, pedClear,
      output mainTrafficLevel, sideTrafficLevel, levelValid, pedRequest
   );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Sync + debounce of vehicle loops and ped button; saturating per-window vehicle counts; latched ped request.
// Latency: raw edge to debounced edge is 1+DEBOUNCE_CYCLES edges; levels refresh once per window; no backpressure.
module traffic_sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WINDOW_CYCLES   = 64
) (
   input logic clk,
   input logic reset,
   traffic_sensor_conditioner_if.slave sensorBus
);
   localparam int MAIN = 0;
   localparam int SIDE = 1;
   localparam int PED  = 2;
   localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

   logic [2:0]  rawIn;
   logic [2:0]  syncS1;
   logic [2:0]  syncS2;
   logic [2:0]  debounced;
   logic [2:0]  flipNow;
   logic [2:0]  riseNow;
   logic [7:0]  stableCnt [3];
   logic [15:0] winCnt;
   logic        winEnd;
   logic [2:0]  mainCount;
   logic [2:0]  sideCount;
   logic [2:0]  mainLevel;
   logic [2:0]  sideLevel;
   logic        levelValidR;
   logic        pedReq;

   function automatic logic [2:0] satInc(input logic [2:0] cnt, input logic ev);
      logic [3:0] sum;
      sum = {1'b0, cnt} + {3'b000, ev};
      return sum[3] ? 3'd7 : sum[2:0];
   endfunction

   assign rawIn  = {sensorBus.pedButtonRaw, sensorBus.sideDetectRaw, sensorBus.mainDetectRaw};
   assign winEnd = (winCnt == WIN_LAST);

   // A channel flips on the edge its stability counter would reach DEBOUNCE_CYCLES.
   always_comb begin
      flipNow = '0;
      riseNow = '0;
      for (int i = 0; i < 3; i++) begin
         flipNow[i] = (syncS2[i] != debounced[i]) && (stableCnt[i] == DEB_LAST);
         riseNow[i] = flipNow[i] & syncS2[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         syncS1      <= '0;
         syncS2      <= '0;
         debounced   <= '0;
         for (int i = 0; i < 3; i++) stableCnt[i] <= '0;
         winCnt      <= '0;
         mainCount   <= '0;
         sideCount   <= '0;
         mainLevel   <= '0;
         sideLevel   <= '0;
         levelValidR <= 1'b0;
         pedReq      <= 1'b0;
      end else begin
         syncS1 <= rawIn;
         syncS2 <= syncS1;

         for (int i = 0; i < 3; i++) begin
            if (flipNow[i]) begin
               debounced[i] <= syncS2[i];
               stableCnt[i] <= '0;
            end else if (syncS2[i] != debounced[i]) begin
               stableCnt[i] <= stableCnt[i] + 8'd1;
            end else begin
               stableCnt[i] <= '0;
            end
         end

         // A rise on the terminal edge belongs to the window that is closing.
         levelValidR <= winEnd;
         if (winEnd) begin
            winCnt    <= '0;
            mainLevel <= satInc(mainCount, riseNow[MAIN]);
            sideLevel <= satInc(sideCount, riseNow[SIDE]);
            mainCount <= '0;
            sideCount <= '0;
         end else begin
            winCnt    <= winCnt + 16'd1;
            mainCount <= satInc(mainCount, riseNow[MAIN]);
            sideCount <= satInc(sideCount, riseNow[SIDE]);
         end

         // Set has priority so a press coinciding with a clear is not lost.
         if (riseNow[PED]) begin
            pedReq <= 1'b1;
         end else if (sensorBus.pedClear) begin
            pedReq <= 1'b0;
         end
      end
   end

   assign sensorBus.mainTrafficLevel = mainLevel;
   assign sensorBus.sideTrafficLevel = sideLevel;
   assign sensorBus.levelValid       = levelValidR;
   assign sensorBus.pedRequest       = pedReq;
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: window phase is tracked by a local edge counter.
module tb_traffic_sensor_conditioner;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   nWait;

   traffic_sensor_conditioner_if bus ();

   traffic_sensor_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .WINDOW_CYCLES(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sensorBus(bus)
   );

   always #5 clk = ~clk;

   // Edges since the last edge that sampled reset high; mod 64 equals the window position.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic checkVal(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tickTo(input int target);
      while (cyc < target) tick(1);
   endtask

   task automatic pulse(input int ch, input int hi, input int lo);
      if (ch == 0) bus.mainDetectRaw = 1'b1;
      else bus.sideDetectRaw = 1'b1;
      tick(hi);
      if (ch == 0) bus.mainDetectRaw = 1'b0;
      else bus.sideDetectRaw = 1'b0;
      tick(lo);
   endtask

   task automatic waitLevel(output int n);
      n = 0;
      while (!bus.levelValid && n < 200) begin
         tick(1);
         n++;
      end
      checkVal("levelValidSeen", int'(bus.levelValid), 1);
   endtask

   initial begin
      bus.mainDetectRaw = 1'b0;
      bus.sideDetectRaw = 1'b0;
      bus.pedButtonRaw  = 1'b0;
      bus.pedClear      = 1'b0;
      tick(3);
      checkVal("rstMain", int'(bus.mainTrafficLevel), 0);
      checkVal("rstValid", int'(bus.levelValid), 0);
      reset = 1'b0;

      // Window 0: three clean main pulses, ped press rising at E66.
      repeat (3) pulse(0, 10, 10);
      bus.pedButtonRaw = 1'b1;
      waitLevel(nWait);
      checkVal("w0Phase", cyc, 64);
      checkVal("w0Main", int'(bus.mainTrafficLevel), 3);
      checkVal("w0Side", int'(bus.sideTrafficLevel), 0);
      tickTo(65);
      checkVal("w0ValidWidth", int'(bus.levelValid), 0);
      checkVal("pedBeforeRise", int'(bus.pedRequest), 0);
      tickTo(66);
      checkVal("pedRise", int'(bus.pedRequest), 1);
      bus.pedButtonRaw = 1'b0;

      // Three more main pulses, then reset mid-window with a partial count of 3.
      repeat (3) pulse(0, 10, 10);
      checkVal("preRstMain", int'(bus.mainTrafficLevel), 3);
      checkVal("preRstPed", int'(bus.pedRequest), 1);
      reset = 1'b1;
      tick(2);
      checkVal("midRstMain", int'(bus.mainTrafficLevel), 0);
      checkVal("midRstSide", int'(bus.sideTrafficLevel), 0);
      checkVal("midRstValid", int'(bus.levelValid), 0);
      checkVal("midRstPed", int'(bus.pedRequest), 0);
      reset = 1'b0;
      waitLevel(nWait);
      checkVal("firstLevelDelay", nWait, 64);
      checkVal("postRstMain", int'(bus.mainTrafficLevel), 0);

      // Bounce: 3-cycle high/low chatter must never debounce.
      repeat (5) pulse(0, 3, 3);
      waitLevel(nWait);
      checkVal("bouncePhase", cyc, 128);
      checkVal("bounceMain", int'(bus.mainTrafficLevel), 0);

      // Five clean side pulses in one window.
      repeat (5) pulse(1, 6, 6);
      waitLevel(nWait);
      checkVal("sidePhase", cyc, 192);
      checkVal("side5", int'(bus.sideTrafficLevel), 5);
      checkVal("side5Main", int'(bus.mainTrafficLevel), 0);
      tick(1);
      checkVal("side5ValidWidth", int'(bus.levelValid), 0);

      // Saturation: eight main rises (E199..E255) in the window ending at E256.
      repeat (7) pulse(0, 4, 4);
      pulse(0, 4, 3);
      waitLevel(nWait);
      checkVal("satPhase", cyc, 256);
      checkVal("satMain", int'(bus.mainTrafficLevel), 7);
      checkVal("satSide", int'(bus.sideTrafficLevel), 0);
      tickTo(260);
      repeat (2) pulse(0, 6, 6);
      waitLevel(nWait);
      checkVal("afterSatPhase", cyc, 320);
      checkVal("afterSatMain", int'(bus.mainTrafficLevel), 2);

      // Debounced rise exactly on the terminal edge E384.
      tickTo(378);
      bus.mainDetectRaw = 1'b1;
      tickTo(384);
      checkVal("boundaryValid", int'(bus.levelValid), 1);
      checkVal("boundaryMain", int'(bus.mainTrafficLevel), 1);
      bus.mainDetectRaw = 1'b0;
      tickTo(400);
      checkVal("levelHold", int'(bus.mainTrafficLevel), 1);
      waitLevel(nWait);
      checkVal("nextWinPhase", cyc, 448);
      checkVal("nextWinMain", int'(bus.mainTrafficLevel), 0);

      // Pedestrian latch: press/hold, clear while held, re-press coinciding with clear.
      bus.pedButtonRaw = 1'b1;
      tickTo(453);
      checkVal("pedEdge4", int'(bus.pedRequest), 0);
      tickTo(454);
      checkVal("pedEdge5", int'(bus.pedRequest), 1);
      tickTo(456);
      bus.pedClear = 1'b1;
      tick(1);
      bus.pedClear = 1'b0;
      checkVal("pedCleared", int'(bus.pedRequest), 0);
      tickTo(467);
      checkVal("pedHeldNoReset", int'(bus.pedRequest), 0);
      bus.pedButtonRaw = 1'b0;
      tickTo(480);
      bus.pedButtonRaw = 1'b1;
      tickTo(485);
      bus.pedClear = 1'b1;
      tick(1);
      bus.pedClear = 1'b0;
      checkVal("pedSetWins", int'(bus.pedRequest), 1);
      tickTo(490);
      checkVal("pedStays", int'(bus.pedRequest), 1);
      bus.pedClear = 1'b1;
      tick(1);
      checkVal("pedClear2", int'(bus.pedRequest), 0);
      tick(1);
      bus.pedClear = 1'b0;
      checkVal("pedClearIdle", int'(bus.pedRequest), 0);
      bus.pedButtonRaw = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
